pipe_skid_stage: RTL
====================

// Module: pipe_skid_stage
// PURPOSE
//  Elastic pipeline stage with a valid/ready handshake on both sides and a two-entry skid buffer.
//  It turns downstream backpressure into a registered in_ready for the upstream stage.
//  Sits between pipeline stages wherever a stall has to travel upstream without a combinational ready chain.
//  Full throughput (1 beat/cycle); no combinational path from input to output on valid, ready or data.
// PARAMETERS
//  WIDTH  8  payload width in bits
// PORTS
//  clk        in   1      single clock, all flops rising-edge
//  reset      in   1      asynchronous, active-low reset (reset==0 clears all state)
//  flush      in   1      synchronous discard of all held beats
//  in_valid   in   1      upstream beat valid
//  in_ready   out  1      stage can accept a beat; driven directly by a flop
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      main register holds a beat
//  out_ready  in   1      downstream accepts
//  out_data   out  WIDTH  payload; driven directly by the main register
//  count      out  2      beats held: 0, 1 or 2
// BEHAVIOUR
//  - in_fire  = in_valid  & in_ready
//  - out_fire = out_valid & out_ready
//  - Reset (reset==0):
//    - state=EMPTY, main=0, skid=0
//    - out_valid=0, count=0
//    - in_ready=0 while in reset; in_ready rises to 1 at the first clk edge after release
//  - State EMPTY (count 0):
//    - in_fire -> ONE, main<=in_data
//  - State ONE (count 1):
//    - in_fire & out_fire  -> ONE, main<=in_data
//    - in_fire & !out_fire -> TWO, skid<=in_data
//    - !in_fire & out_fire -> EMPTY
//  - State TWO (count 2):
//    - in_ready=0, so no in_fire is possible
//    - out_fire -> ONE, main<=skid
//  - in_ready (registered): next value = (next_state != TWO) && !flush-hold.
//    - It drops in the cycle after the skid buffer fills.
//    - It is never a function of out_ready in the same cycle.
//  - out_valid = (state != EMPTY). out_data is valid only while out_valid=1.
//  - Latency: a beat accepted on edge N is presented at out_data after edge N (1 cycle) when the stage is EMPTY or draining.
//  - Ordering: strict FIFO; no beat is duplicated or dropped except by flush or reset.
//  - Holding rules:
//    - While out_valid=1 and out_ready=0, out_data and out_valid stay stable.
//    - The upstream must hold in_data stable while in_valid=1 and in_ready=0.
//  - flush=1: next state EMPTY, count 0.
//    - Any in_fire or out_fire in the same cycle is ignored (the beat is discarded).
//    - in_ready is 1 on the following cycle.
//  - Reset mid-operation: held beats are lost immediately (async); there is no partial handshake afterwards.
//  - count tracks state exactly: EMPTY=0, ONE=1, TWO=2; the value 3 never occurs.
// STRUCTURE
//  - Shared package header pipe_pkg.vh:
//    - state localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2
//    - the handshake fire macros
//  - No sub-module. Two WIDTH-bit enabled data registers (main, skid), plus the 2-bit state flop and the in_ready flop, inline.
//  - Next-state logic lives in one combinational block; all flops use async active-low reset.
// TESTING
//  - Reset: hold reset=0 with in_valid=1 -> in_ready=0, out_valid=0, count=0; after release, in_ready=1 on the next edge.
//  - Streaming: WIDTH=8, beats 0x01..0x10 back-to-back, out_ready=1 -> same sequence out, 1 beat/cycle, 1-cycle latency, count stays 1.
//  - Stall: out_ready=0 while sending 0xA1,0xA2,0xA3 ->
//    - count goes 1 then 2, in_ready=0 after 0xA2, 0xA3 is held upstream
//    - after out_ready=1: 0xA1,0xA2,0xA3 in order
//  - Simultaneous: in state ONE with main=0x55, in_fire(0x66) and out_fire together -> 0x55 consumed, out_data=0x66, count=1.
//  - Flush: in state TWO (0x11,0x22), flush=1 with in_valid=1 (0x33) ->
//    - next cycle out_valid=0, count=0, in_ready=1
//    - 0x11, 0x22 and 0x33 never appear at the output
//  - Random: random in_valid and out_ready for 10k cycles against a scoreboard FIFO -> no loss, duplication or reorder; stable-hold assertions pass.

Source files
------------

// File: rtl/pipe_skid_stage_pkg.sv
// Shared definitions for the elastic skid stage: occupancy states and the handshake fire helper.
package pipe_skid_stage_pkg;

    // Encoding doubles as the beat count driven on the count port.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    function automatic logic fire(input logic valid, input logic ready);
        return valid & ready;
    endfunction

endpackage

// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready pipeline stage with a two-entry skid buffer; in_ready and out_data come
// straight from flops so no combinational path crosses the stage.
module pipe_skid_stage
    import pipe_skid_stage_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [1:0]       count
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic             r_in_ready;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_load_main;
    logic             w_main_from_skid;
    logic             w_load_skid;

    assign in_ready  = r_in_ready;
    assign out_valid = (r_state != ST_EMPTY);
    assign out_data  = r_main;
    assign count     = r_state;

    always_comb begin
        w_in_fire        = fire(in_valid, r_in_ready);
        w_out_fire       = fire(out_valid, out_ready);
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_main_from_skid = 1'b0;
        w_load_skid      = 1'b0;
        // Flush overrides every handshake in the same cycle; the beats are simply dropped.
        if (flush) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = ST_ONE;
                        w_load_main = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        w_load_main = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_nxt = ST_TWO;
                        w_load_skid = 1'b1;
                    end else if (w_out_fire) begin
                        w_state_nxt = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_out_fire) begin
                        w_state_nxt      = ST_ONE;
                        w_load_main      = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_TWO);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_main <= '0;
        end else if (w_load_main) begin
            r_main <= w_main_from_skid ? r_skid : in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_skid <= '0;
        end else if (w_load_skid) begin
            r_skid <= in_data;
        end
    end

endmodule
